// File: rtl/ctrl_reg_pipe_if.sv
// ----------------------------------------------------------------------------
// ctrl_reg_pipe_if
// Purpose : bundles the issue, write-back, load and read-out signals of
//           ctrl_reg_pipe so the block and its driver share one declaration.
// Modports:
//   master - instruction/data source (drives requests, observes results)
//   slave  - ctrl_reg_pipe itself
// Signals :
//   InstValid/InstReady       issue handshake
//   RdAddrA/RdAddrB/TgtAddr   read addresses (A bits)
//   WrEn/WrSel/WrAddr         write request, source select (0 ALU, 1 load)
//   BrEn/Halt                 branch-if-equal and halt requests
//   ALUData/MemData           write-back sources (W bits)
//   MemReq/MemValid           load handshake
//   DataOutA/DataOutB/PCTarget read data (W bits)
//   BranchTaken/Ack           branch resolved taken, halted and drained
// ----------------------------------------------------------------------------
interface ctrl_reg_pipe_if #(
    parameter int W = 8,
    parameter int A = 4
) ();
    logic         InstValid;
    logic         InstReady;
    logic [A-1:0] RdAddrA;
    logic [A-1:0] RdAddrB;
    logic [A-1:0] TgtAddr;
    logic         WrEn;
    logic         WrSel;
    logic [A-1:0] WrAddr;
    logic         BrEn;
    logic         Halt;
    logic [W-1:0] ALUData;
    logic [W-1:0] MemData;
    logic         MemReq;
    logic         MemValid;
    logic [W-1:0] DataOutA;
    logic [W-1:0] DataOutB;
    logic [W-1:0] PCTarget;
    logic         BranchTaken;
    logic         Ack;

    modport master (
        output InstValid, RdAddrA, RdAddrB, TgtAddr, WrEn, WrSel, WrAddr,
               BrEn, Halt, ALUData, MemData, MemValid,
        input  InstReady, MemReq, DataOutA, DataOutB, PCTarget, BranchTaken, Ack
    );

    modport slave (
        input  InstValid, RdAddrA, RdAddrB, TgtAddr, WrEn, WrSel, WrAddr,
               BrEn, Halt, ALUData, MemData, MemValid,
        output InstReady, MemReq, DataOutA, DataOutB, PCTarget, BranchTaken, Ack
    );
endinterface

// File: rtl/ctrl_reg_pipe.sv
// ----------------------------------------------------------------------------
// ctrl_reg_pipe
// Purpose : 2**A x W register file with three combinational read ports
//           (A, B, branch target), a single write-back stage that commits one
//           edge after it is loaded, a memory-load handshake and a halt state.
//           A RUN/LOAD/HALT controller gates instruction issue.
// Ports   :
//   Clk    - single clock, rising edge
//   Reset  - asynchronous, active-low reset
//   bus    - ctrl_reg_pipe_if.slave (issue, write, branch, load, read-out)
// Config  : define CTRL_REG_PIPE_BYPASS_EN to forward the write-back stage
//           onto the read ports; otherwise a read that hits the pending
//           write-back address stalls issue for one cycle.
// ----------------------------------------------------------------------------
module ctrl_reg_pipe #(
    parameter int W = 8,
    parameter int A = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    ctrl_reg_pipe_if.slave  bus
);
    localparam int N = 2 ** A;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_nextState;

    logic [W-1:0] r_regFile [N];
    logic         r_wbValid;
    logic [A-1:0] r_wbAddr;
    logic [W-1:0] r_wbData;
    logic [A-1:0] r_loadAddr;
    logic         r_haltAfterLoad;
    // Holds issue off until the first edge after reset is released.
    logic         r_live;

    logic [W-1:0] w_rdA;
    logic [W-1:0] w_rdB;
    logic [W-1:0] w_rdT;
    logic         w_hazard;
    logic         w_instReady;
    logic         w_accept;
    logic         w_aluWrite;
    logic         w_loadStart;
    logic         w_loadDone;
    logic         w_memReq;
    logic         w_ack;

    // Read ports: array content, optionally overridden by the pending
    // write-back. Without forwarding, a match on any read address is a hazard.
    always_comb begin
        w_rdA    = r_regFile[bus.RdAddrA];
        w_rdB    = r_regFile[bus.RdAddrB];
        w_rdT    = r_regFile[bus.TgtAddr];
        w_hazard = 1'b0;
`ifdef CTRL_REG_PIPE_BYPASS_EN
        if (r_wbValid && (bus.RdAddrA == r_wbAddr)) w_rdA = r_wbData;
        if (r_wbValid && (bus.RdAddrB == r_wbAddr)) w_rdB = r_wbData;
        if (r_wbValid && (bus.TgtAddr == r_wbAddr)) w_rdT = r_wbData;
`else
        w_hazard = r_wbValid && ((bus.RdAddrA == r_wbAddr) ||
                                 (bus.RdAddrB == r_wbAddr) ||
                                 (bus.TgtAddr == r_wbAddr));
`endif
    end

    // The stall lasts one cycle because the stage commits and clears on the
    // next edge; nothing can reload it while issue is blocked.
    assign w_instReady = r_live && (r_state == ST_RUN) && !w_hazard;
    assign w_accept    = bus.InstValid && w_instReady;
    assign w_aluWrite  = w_accept && bus.WrEn && !bus.WrSel;
    assign w_loadStart = w_accept && bus.WrEn && bus.WrSel;
    assign w_loadDone  = (r_state == ST_LOAD) && bus.MemValid;

    // Controller next-state and state-dependent outputs.
    // A halt that arrives with a load is remembered and taken after the load.
    always_comb begin
        w_nextState = r_state;
        w_memReq    = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_loadStart) begin
                    w_nextState = ST_LOAD;
                end else if (w_accept && bus.Halt) begin
                    w_nextState = ST_HALT;
                end
            end
            ST_LOAD: begin
                w_memReq = 1'b1;
                if (bus.MemValid) begin
                    w_nextState = r_haltAfterLoad ? ST_HALT : ST_RUN;
                end
            end
            ST_HALT: begin
                w_ack = !r_wbValid;
            end
            default: begin
                w_nextState = ST_RUN;
            end
        endcase
    end

    // State, write-back stage and register file. The stage commits what it
    // held before this edge while being reloaded, so a same-address write and
    // commit on one edge keep the older value in the array.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state         <= ST_RUN;
            r_live          <= 1'b0;
            r_wbValid       <= 1'b0;
            r_wbAddr        <= '0;
            r_wbData        <= '0;
            r_loadAddr      <= '0;
            r_haltAfterLoad <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_regFile[i] <= '0;
            end
        end else begin
            r_state   <= w_nextState;
            r_live    <= 1'b1;
            r_wbValid <= 1'b0;
            if (r_wbValid) begin
                r_regFile[r_wbAddr] <= r_wbData;
            end
            if (w_aluWrite) begin
                r_wbValid <= 1'b1;
                r_wbAddr  <= bus.WrAddr;
                r_wbData  <= bus.ALUData;
            end else if (w_loadDone) begin
                r_wbValid <= 1'b1;
                r_wbAddr  <= r_loadAddr;
                r_wbData  <= bus.MemData;
            end
            if (w_loadStart) begin
                r_loadAddr      <= bus.WrAddr;
                r_haltAfterLoad <= bus.Halt;
            end
        end
    end

    assign bus.InstReady   = w_instReady;
    assign bus.MemReq      = w_memReq;
    assign bus.Ack         = w_ack;
    assign bus.DataOutA    = w_rdA;
    assign bus.DataOutB    = w_rdB;
    assign bus.PCTarget    = w_rdT;
    assign bus.BranchTaken = w_accept && bus.BrEn && (w_rdA == w_rdB);
endmodule

// File: tb/tb_ctrl_reg_pipe.sv
// ----------------------------------------------------------------------------
// tb_ctrl_reg_pipe
// Directed stimulus for ctrl_reg_pipe with a behavioural model of the
// architectural registers and pending writes, compared on every falling edge,
// plus hand-computed literal expectations for the named scenarios.
// ----------------------------------------------------------------------------
module tb_ctrl_reg_pipe;
    localparam int W = 8;
    localparam int A = 4;
    localparam int N = 16;

`ifdef CTRL_REG_PIPE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam int M_RUN  = 0;
    localparam int M_LOAD = 1;
    localparam int M_HALT = 2;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    always #5 Clk = ~Clk;

    ctrl_reg_pipe_if #(.W(W), .A(A)) bus ();

    ctrl_reg_pipe #(.W(W), .A(A)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int compareCount  = 0;
    int mismatchCount = 0;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [A-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    logic [W-1:0] mReg [N];
    wr_t          pendQ [$];
    wr_t          mWr;
    int           mMode;
    logic         mLive;
    logic         mAcc;
    logic [A-1:0] mLoadAddr;
    logic         mHaltAfter;

    // What a read port must show: the architectural value, or the not yet
    // committed write when forwarding is built in.
    function automatic logic [W-1:0] expRead(input logic [A-1:0] addr);
        if (BYPASS && (pendQ.size() > 0)) begin
            if (pendQ[pendQ.size()-1].addr == addr) return pendQ[pendQ.size()-1].data;
        end
        return mReg[addr];
    endfunction

    // Issue is open in RUN once out of reset, unless a read touches a write
    // still in flight and there is no forwarding.
    function automatic logic expReady();
        if (!mLive || (mMode != M_RUN)) return 1'b0;
        if (BYPASS) return 1'b1;
        foreach (pendQ[k]) begin
            if ((pendQ[k].addr == bus.RdAddrA) || (pendQ[k].addr == bus.RdAddrB) ||
                (pendQ[k].addr == bus.TgtAddr)) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            foreach (mReg[k]) mReg[k] = '0;
            pendQ.delete();
            mMode      = M_RUN;
            mLive      = 1'b0;
            mLoadAddr  = '0;
            mHaltAfter = 1'b0;
        end else begin
            mAcc = bus.InstValid && expReady();
            while (pendQ.size() > 0) begin
                mWr = pendQ.pop_front();
                mReg[mWr.addr] = mWr.data;
            end
            if ((mMode == M_RUN) && mAcc) begin
                if (bus.WrEn && !bus.WrSel) begin
                    mWr.addr = bus.WrAddr;
                    mWr.data = bus.ALUData;
                    pendQ.push_back(mWr);
                end
                if (bus.WrEn && bus.WrSel) begin
                    mLoadAddr  = bus.WrAddr;
                    mHaltAfter = bus.Halt;
                    mMode      = M_LOAD;
                end else if (bus.Halt) begin
                    mMode = M_HALT;
                end
            end else if ((mMode == M_LOAD) && bus.MemValid) begin
                mWr.addr = mLoadAddr;
                mWr.data = bus.MemData;
                pendQ.push_back(mWr);
                mMode = mHaltAfter ? M_HALT : M_RUN;
            end
            mLive = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge Clk) begin
        checkOutput("mdl_InstReady", 32'(bus.InstReady), 32'(expReady()));
        checkOutput("mdl_MemReq", 32'(bus.MemReq), 32'(mMode == M_LOAD));
        checkOutput("mdl_Ack", 32'(bus.Ack), 32'((mMode == M_HALT) && (pendQ.size() == 0)));
        checkOutput("mdl_DataOutA", 32'(bus.DataOutA), 32'(expRead(bus.RdAddrA)));
        checkOutput("mdl_DataOutB", 32'(bus.DataOutB), 32'(expRead(bus.RdAddrB)));
        checkOutput("mdl_PCTarget", 32'(bus.PCTarget), 32'(expRead(bus.TgtAddr)));
        checkOutput("mdl_BranchTaken", 32'(bus.BranchTaken),
                    32'(bus.InstValid && expReady() && bus.BrEn &&
                        (expRead(bus.RdAddrA) == expRead(bus.RdAddrB))));
    end

    // ---------------- stimulus helpers ----------------
    task automatic nextEdge();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        @(negedge Clk);
    endtask

    task automatic applyStimulus(input logic [A-1:0] rdA, input logic [A-1:0] rdB,
                                 input logic [A-1:0] tgt, input logic wrEn,
                                 input logic wrSel, input logic [A-1:0] wrAddr,
                                 input logic brEn, input logic halt,
                                 input logic [W-1:0] alu);
        bus.RdAddrA = rdA;
        bus.RdAddrB = rdB;
        bus.TgtAddr = tgt;
        bus.WrEn    = wrEn;
        bus.WrSel   = wrSel;
        bus.WrAddr  = wrAddr;
        bus.BrEn    = brEn;
        bus.Halt    = halt;
        bus.ALUData = alu;
    endtask

    // Holds InstValid until accepted (bounded), then drops the request.
    task automatic issueUntilAccepted(input string name);
        int waitCycles;
        waitCycles = 0;
        bus.InstValid = 1'b1;
        settle();
        while (!bus.InstReady && (waitCycles < 20)) begin
            waitCycles++;
            nextEdge();
            settle();
        end
        if (!bus.InstReady) begin
            compareCount++;
            mismatchCount++;
            $display("[TB] FAIL %s: accept timeout, InstReady stayed 0 for %0d cycles, required 1", name, waitCycles);
        end
        nextEdge();
        bus.InstValid = 1'b0;
        bus.WrEn      = 1'b0;
        bus.BrEn      = 1'b0;
        bus.Halt      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int memReqCycles;
        bus.InstValid = 1'b0;
        bus.MemValid  = 1'b0;
        bus.MemData   = '0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        #1 Reset = 1'b0;

        // Reset values and first-edge readiness
        settle();
        checkOutput("rst_InstReady", 32'(bus.InstReady), 32'h0);
        checkOutput("rst_MemReq", 32'(bus.MemReq), 32'h0);
        checkOutput("rst_Ack", 32'(bus.Ack), 32'h0);
        checkOutput("rst_DataOutA", 32'(bus.DataOutA), 32'h0);
        nextEdge();
        Reset = 1'b1;
        settle();
        checkOutput("ready_before_first_edge", 32'(bus.InstReady), 32'h0);
        nextEdge();
        settle();
        checkOutput("ready_after_first_edge", 32'(bus.InstReady), 32'h1);
        nextEdge();
        for (int i = 0; i < N; i++) begin
            applyStimulus(A'(i), A'(N - 1 - i), A'(i), 0, 0, 0, 0, 0, 8'h00);
            settle();
            checkOutput("rst_read_A", 32'(bus.DataOutA), 32'h0);
            checkOutput("rst_read_T", 32'(bus.PCTarget), 32'h0);
            nextEdge();
        end

        // ALU write r5 then immediate read of r5
        applyStimulus(0, 0, 0, 1, 0, 5, 0, 0, 8'h3C);
        issueUntilAccepted("wr_r5");
        applyStimulus(5, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        bus.InstValid = 1'b1;
        settle();
        checkOutput("r5_first_ready", 32'(bus.InstReady), BYPASS ? 32'h1 : 32'h0);
        checkOutput("r5_first_read", 32'(bus.DataOutA), BYPASS ? 32'h3C : 32'h0);
        nextEdge();
        settle();
        checkOutput("r5_second_ready", 32'(bus.InstReady), 32'h1);
        checkOutput("r5_second_read", 32'(bus.DataOutA), 32'h3C);
        nextEdge();
        bus.InstValid = 1'b0;

        // MemValid outside LOAD must be ignored
        bus.MemValid = 1'b1;
        bus.MemData  = 8'h99;
        applyStimulus(2, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        nextEdge();
        bus.MemValid = 1'b0;
        bus.MemData  = 8'h00;
        nextEdge();
        settle();
        checkOutput("stray_memvalid_r2", 32'(bus.DataOutA), 32'h0);
        nextEdge();

        // Load r2 with three idle MemValid cycles
        applyStimulus(2, 0, 0, 1, 1, 2, 0, 0, 8'h00);
        issueUntilAccepted("load_r2");
        memReqCycles = 0;
        for (int c = 0; c < 3; c++) begin
            settle();
            if (bus.MemReq) memReqCycles++;
            checkOutput("load_ready_low", 32'(bus.InstReady), 32'h0);
            nextEdge();
        end
        bus.MemValid = 1'b1;
        bus.MemData  = 8'hA7;
        settle();
        if (bus.MemReq) memReqCycles++;
        nextEdge();
        bus.MemValid = 1'b0;
        bus.MemData  = 8'h00;
        checkOutput("load_memreq_cycles", 32'(memReqCycles), 32'd4);
        settle();
        checkOutput("load_memreq_done", 32'(bus.MemReq), 32'h0);
        checkOutput("r2_one_edge", 32'(bus.DataOutA), BYPASS ? 32'hA7 : 32'h0);
        nextEdge();
        settle();
        checkOutput("r2_two_edges", 32'(bus.DataOutA), 32'hA7);
        nextEdge();

        // Branch-if-equal
        applyStimulus(0, 0, 0, 1, 0, 1, 0, 0, 8'h11);
        issueUntilAccepted("wr_r1");
        applyStimulus(0, 0, 0, 1, 0, 3, 0, 0, 8'h11);
        issueUntilAccepted("wr_r3");
        applyStimulus(0, 0, 0, 1, 0, 4, 0, 0, 8'h40);
        issueUntilAccepted("wr_r4");
        nextEdge();
        applyStimulus(1, 3, 4, 0, 0, 0, 1, 0, 8'h00);
        bus.InstValid = 1'b1;
        settle();
        checkOutput("br_equal_taken", 32'(bus.BranchTaken), 32'h1);
        checkOutput("br_pctarget", 32'(bus.PCTarget), 32'h40);
        checkOutput("br_r1", 32'(bus.DataOutA), 32'h11);
        nextEdge();
        bus.InstValid = 1'b0;
        applyStimulus(0, 0, 0, 1, 0, 3, 0, 0, 8'h12);
        issueUntilAccepted("wr_r3_new");
        nextEdge();
        applyStimulus(1, 3, 4, 0, 0, 0, 1, 0, 8'h00);
        bus.InstValid = 1'b1;
        settle();
        checkOutput("br_unequal_not_taken", 32'(bus.BranchTaken), 32'h0);
        checkOutput("br_r3_new", 32'(bus.DataOutB), 32'h12);
        nextEdge();
        bus.InstValid = 1'b0;
        applyStimulus(1, 1, 4, 0, 0, 0, 1, 0, 8'h00);
        settle();
        checkOutput("br_no_valid", 32'(bus.BranchTaken), 32'h0);
        nextEdge();

        // Back-to-back writes to one address commit in order
        applyStimulus(0, 0, 0, 1, 0, 9, 0, 0, 8'h21);
        issueUntilAccepted("wr_r9_a");
        applyStimulus(0, 0, 0, 1, 0, 9, 0, 0, 8'h22);
        issueUntilAccepted("wr_r9_b");
        applyStimulus(9, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        settle();
        checkOutput("r9_mid", 32'(bus.DataOutA), BYPASS ? 32'h22 : 32'h21);
        nextEdge();
        settle();
        checkOutput("r9_final", 32'(bus.DataOutA), 32'h22);
        nextEdge();

        // Reset in the middle of a load
        applyStimulus(6, 1, 4, 1, 1, 6, 0, 0, 8'h00);
        issueUntilAccepted("load_r6");
        settle();
        checkOutput("mid_load_memreq", 32'(bus.MemReq), 32'h1);
        nextEdge();
        Reset = 1'b0;
        settle();
        checkOutput("rst_load_memreq", 32'(bus.MemReq), 32'h0);
        checkOutput("rst_load_ready", 32'(bus.InstReady), 32'h0);
        checkOutput("rst_load_r1", 32'(bus.DataOutB), 32'h0);
        checkOutput("rst_load_r4", 32'(bus.PCTarget), 32'h0);
        nextEdge();
        Reset = 1'b1;
        bus.MemValid = 1'b1;
        bus.MemData  = 8'h66;
        settle();
        checkOutput("post_rst_memreq", 32'(bus.MemReq), 32'h0);
        nextEdge();
        bus.MemValid = 1'b0;
        bus.MemData  = 8'h00;
        nextEdge();
        settle();
        checkOutput("post_rst_r6", 32'(bus.DataOutA), 32'h0);
        checkOutput("post_rst_ready", 32'(bus.InstReady), 32'h1);
        nextEdge();

        // Halt together with a write of r7
        applyStimulus(7, 0, 0, 1, 0, 7, 0, 1, 8'hFF);
        issueUntilAccepted("wr_r7_halt");
        settle();
        checkOutput("halt_ack_before_commit", 32'(bus.Ack), 32'h0);
        checkOutput("halt_ready_low", 32'(bus.InstReady), 32'h0);
        nextEdge();
        bus.InstValid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            checkOutput("halt_ack", 32'(bus.Ack), 32'h1);
            checkOutput("halt_r7", 32'(bus.DataOutA), 32'hFF);
            checkOutput("halt_ready_stays_low", 32'(bus.InstReady), 32'h0);
            nextEdge();
        end
        bus.InstValid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
